uart_fifo_ctrl: RTL and testbench

Parametrised, fully synchronous UART controller with independent RX and TX FIFOs.
- Replaces the edge-clocked pointer scheme of the current 16-byte UART top: every pointer, counter and flag is clocked by CLK only.
- Uses valid/ready streaming handshakes on the user side.
- Adds configurable data width, FIFO depth and stop bits, plus sticky overrun and framing-error flags.
- Sits between the board RX/TX pins and the user logic that builds frames.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_fifo_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and sizing helpers for uart_fifo_ctrl
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    function automatic int bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through FIFO with occupancy counter; reads 0 while empty
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = addr_w(DEPTH)
)(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    logic          w_push, w_pop;

    assign o_full  = r_level == (AW+1)'(DEPTH);
    assign o_empty = r_level == '0;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];
    assign o_level = r_level;

    // storage array, left unreset so it can map onto RAM
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    // pointers wrap at AW bits; the level counter disambiguates full from empty
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: synchronous UART with RX/TX FWFT FIFOs and sticky errors; parity enabled by UART_PARITY_EN
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    localparam int AW        = addr_w(FIFO_DEPTH)
)(
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 RX_PIN,
    output logic                 TX_PIN,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic [AW:0]          TX_LEVEL,
    output logic [AW:0]          RX_LEVEL,
    output logic                 TX_IDLE,
    output logic                 RX_OVERRUN,
    output logic                 RX_FRAME_ERR,
    output logic                 RX_PARITY_ERR,
    input  logic                 ERR_CLR
);
    localparam int BPS = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int CW  = $clog2(STOP_BITS * BPS + 1);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END  = CW'(BPS - 1);
    localparam logic [CW-1:0] HALF     = CW'(BPS / 2);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * BPS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_t          r_tx_state, w_tx_state, r_rx_state, w_rx_state;
    logic [CW-1:0]        r_tx_cnt, w_tx_cnt, r_rx_cnt, w_rx_cnt;
    logic [BW-1:0]        r_tx_bit, w_tx_bit, r_rx_bit, w_rx_bit;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift, w_tx_head, r_rx_shift, w_rx_shift;
    logic                 r_tx_pin, w_tx_pin, w_tx_pop, w_tx_empty, w_tx_full;
    logic [1:0]           r_rx_sync;
    logic                 r_rx_prev, w_rx, w_rx_fall, w_rx_full, w_rx_empty;
    logic                 w_stop_ok, w_stop_bad, w_par_ok, w_rx_push;
    logic                 r_overrun, r_frame_err;
`ifdef UART_PARITY_EN
    logic                 r_tx_par, w_tx_par, r_rx_par, w_rx_par, r_parity_err;
`endif

    uart_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .CLK(CLK), .RST_N(RST_N), .i_push(TX_VALID), .i_wdata(TX_DATA), .i_pop(w_tx_pop),
        .o_rdata(w_tx_head), .o_level(TX_LEVEL), .o_full(w_tx_full), .o_empty(w_tx_empty)
    );

    uart_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .CLK(CLK), .RST_N(RST_N), .i_push(w_rx_push), .i_wdata(r_rx_shift), .i_pop(RX_READY),
        .o_rdata(RX_DATA), .o_level(RX_LEVEL), .o_full(w_rx_full), .o_empty(w_rx_empty)
    );

    assign TX_READY   = ~w_tx_full;
    assign TX_PIN     = r_tx_pin;
    assign TX_IDLE    = w_tx_empty & (r_tx_state == IDLE);
    assign RX_VALID   = ~w_rx_empty;
    assign RX_OVERRUN   = r_overrun;
    assign RX_FRAME_ERR = r_frame_err;
    assign w_rx       = r_rx_sync[1];
    assign w_rx_fall  = r_rx_prev & ~w_rx;
`ifdef UART_PARITY_EN
    assign w_par_ok      = (^r_rx_shift ^ r_rx_par) == PARITY_ODD[0];
    assign RX_PARITY_ERR = r_parity_err;
`else
    assign w_par_ok      = 1'b1;
    assign RX_PARITY_ERR = 1'b0;
`endif
    assign w_rx_push  = w_stop_ok & w_par_ok & ~w_rx_full;

    // TX next state: pop on leaving IDLE or at end of STOP so frames run back to back
    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_cnt   = r_tx_cnt + CW'(1);
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_tx_pop   = 1'b0;
        case (r_tx_state)
            IDLE: begin
                w_tx_cnt = '0;
                if (!w_tx_empty) begin
                    w_tx_pop   = 1'b1;
                    w_tx_state = START;
                end
            end
            START: if (r_tx_cnt == BIT_END) begin
                w_tx_cnt   = '0;
                w_tx_bit   = '0;
                w_tx_state = DATA;
            end
            DATA: if (r_tx_cnt == BIT_END) begin
                w_tx_cnt   = '0;
                w_tx_bit   = r_tx_bit + BW'(1);
                w_tx_shift = r_tx_shift >> 1;
`ifdef UART_PARITY_EN
                if (r_tx_bit == LAST_BIT) w_tx_state = PARITY;
`else
                if (r_tx_bit == LAST_BIT) w_tx_state = STOP;
`endif
            end
`ifdef UART_PARITY_EN
            PARITY: if (r_tx_cnt == BIT_END) begin
                w_tx_cnt   = '0;
                w_tx_state = STOP;
            end
`endif
            STOP: if (r_tx_cnt == STOP_END) begin
                w_tx_cnt   = '0;
                w_tx_pop   = ~w_tx_empty;
                w_tx_state = w_tx_empty ? IDLE : START;
            end
            default: w_tx_state = IDLE;
        endcase
        if (w_tx_pop) w_tx_shift = w_tx_head;
`ifdef UART_PARITY_EN
        w_tx_par = w_tx_pop ? (^w_tx_head ^ PARITY_ODD[0]) : r_tx_par;
`endif
        w_tx_pin = 1'b1;
        if (w_tx_state == START) w_tx_pin = 1'b0;
        if (w_tx_state == DATA) w_tx_pin = w_tx_shift[0];
`ifdef UART_PARITY_EN
        if (w_tx_state == PARITY) w_tx_pin = w_tx_par;
`endif
    end

    // TX registers; the line is registered from the next state so it never glitches
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_pin   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_tx_pin   <= w_tx_pin;
        end
    end

    // RX next state: sample mid-bit, return to IDLE right after the stop sample
    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_cnt   = r_rx_cnt + CW'(1);
        w_rx_bit   = r_rx_bit;
        w_rx_shift = r_rx_shift;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par   = r_rx_par;
`endif
        case (r_rx_state)
            IDLE: begin
                w_rx_cnt = '0;
                if (w_rx_fall) w_rx_state = START;
            end
            START: if (r_rx_cnt == HALF) begin
                w_rx_cnt   = '0;
                w_rx_bit   = '0;
                w_rx_state = w_rx ? IDLE : DATA;
            end
            DATA: if (r_rx_cnt == BIT_END) begin
                w_rx_cnt   = '0;
                w_rx_bit   = r_rx_bit + BW'(1);
                w_rx_shift = {w_rx, r_rx_shift[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
                if (r_rx_bit == LAST_BIT) w_rx_state = PARITY;
`else
                if (r_rx_bit == LAST_BIT) w_rx_state = STOP;
`endif
            end
`ifdef UART_PARITY_EN
            PARITY: if (r_rx_cnt == BIT_END) begin
                w_rx_cnt   = '0;
                w_rx_par   = w_rx;
                w_rx_state = STOP;
            end
`endif
            STOP: if (r_rx_cnt == BIT_END) begin
                w_stop_ok  = w_rx;
                w_stop_bad = ~w_rx;
                w_rx_state = IDLE;
            end
            default: w_rx_state = IDLE;
        endcase
    end

    // RX synchroniser, edge history and deserialiser registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], RX_PIN};
            r_rx_prev  <= w_rx;
            r_rx_state <= w_rx_state;
            r_rx_cnt   <= w_rx_cnt;
            r_rx_bit   <= w_rx_bit;
            r_rx_shift <= w_rx_shift;
        end
    end

    // sticky error flags; a clear wins over an error arriving in the same cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= ERR_CLR ? 1'b0 : r_overrun | (w_stop_ok & w_par_ok & w_rx_full);
            r_frame_err <= ERR_CLR ? 1'b0 : r_frame_err | w_stop_bad;
        end
    end

`ifdef UART_PARITY_EN
    // parity state: TX bit latched with the character, RX bit captured mid-bit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tx_par     <= 1'b0;
            r_rx_par     <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_tx_par     <= w_tx_par;
            r_rx_par     <= w_rx_par;
            r_parity_err <= ERR_CLR ? 1'b0 : r_parity_err | (w_stop_ok & ~w_par_ok);
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed self-checking bench for uart_fifo_ctrl at 10 clocks per bit
`timescale 1ns/1ps
module tb_uart_fifo_ctrl;
    localparam int BPS = 10;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
    localparam logic [NB-1:0] A5_FRAME = 11'b10101001010;
`else
    localparam int NB = 10;
    localparam logic [NB-1:0] A5_FRAME = 10'b1101001010;
`endif
    localparam int FL = NB * BPS;

    logic       clk = 1'b0, rst_n = 1'b0, rx_pin = 1'b1, tx_valid = 1'b0, rx_ready = 1'b0, err_clr = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_pin, tx_ready, rx_valid, tx_idle, rx_overrun, rx_frame_err, rx_parity_err;
    logic [7:0] rx_data;
    logic [4:0] tx_level, rx_level;
    int         n_vec = 0, n_err = 0;

    uart_fifo_ctrl #(
        .CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8),
        .FIFO_DEPTH(16), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .RX_PIN(rx_pin), .TX_PIN(tx_pin),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
        .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
        .TX_LEVEL(tx_level), .RX_LEVEL(rx_level), .TX_IDLE(tx_idle),
        .RX_OVERRUN(rx_overrun), .RX_FRAME_ERR(rx_frame_err),
        .RX_PARITY_ERR(rx_parity_err), .ERR_CLR(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic send_rx(input logic [7:0] d, input logic p, input logic stop);
        rx_pin = 1'b0;
        repeat (BPS) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            rx_pin = d[j];
            repeat (BPS) @(negedge clk);
        end
        rx_pin = p;
`ifdef UART_PARITY_EN
        repeat (BPS) @(negedge clk);
`endif
        rx_pin = stop;
        repeat (BPS) @(negedge clk);
        rx_pin = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] exp_frm;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx_pin", tx_pin, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_tx_idle", tx_idle, 1);
        check("rst_errs", {rx_overrun, rx_frame_err, rx_parity_err}, 0);

        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("a5_pre_start_pin", tx_pin, 1);
        check("a5_level", tx_level, 1);
        check("a5_not_idle", tx_idle, 0);
        @(negedge clk);
        check("a5_start_edge", tx_pin, 0);
        exp_frm = A5_FRAME;
        repeat (5) @(negedge clk);
        for (int j = 0; j < NB; j++) begin
            check($sformatf("a5_bit%0d", j), tx_pin, exp_frm[j]);
            if (j < NB - 1) repeat (BPS) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("a5_stop_busy", tx_idle, 0);
        @(negedge clk);
        check("a5_idle_after", tx_idle, 1);
        repeat (3) @(negedge clk);

        fork
            begin
                logic [NB-1:0] frm;
                repeat (7) @(negedge clk);
                for (int k = 0; k < 17; k++) begin
                    for (int j = 0; j < NB; j++) begin
                        frm[j] = tx_pin;
                        repeat (BPS) @(negedge clk);
                    end
                    check($sformatf("burst_frame%0d", k), frm, frame_of(8'(k)));
                end
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    if (k == 16) check("burst_ready_at15", tx_ready, 1);
                    tx_data = 8'(k);
                    tx_valid = 1'b1;
                    @(negedge clk);
                end
                tx_data = 8'h11;
                check("burst_full_ready", tx_ready, 0);
                check("burst_full_level", tx_level, 16);
                repeat (FL - 16) @(negedge clk);
                check("burst_nobypass_ready", tx_ready, 0);
                check("burst_nobypass_level", tx_level, 16);
                @(negedge clk);
                check("burst_pop_level", tx_level, 15);
                check("burst_pop_ready", tx_ready, 1);
                tx_valid = 1'b0;
            end
        join
        check("burst_idle", tx_idle, 1);
        check("burst_level0", tx_level, 0);

        send_rx(8'h3C, ^8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        check("rx3c_valid", rx_valid, 1);
        check("rx3c_data", rx_data, 8'h3C);
        check("rx3c_level", rx_level, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx3c_pop_valid", rx_valid, 0);
        check("rx3c_pop_level", rx_level, 0);

        for (int k = 0; k < 17; k++) send_rx(8'(16 + k), ^(8'(16 + k)), 1'b1);
        repeat (2) @(negedge clk);
        check("ovr_level", rx_level, 16);
        check("ovr_flag", rx_overrun, 1);
        check("ovr_no_frame_err", rx_frame_err, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ovr_cleared", rx_overrun, 0);
        check("ovr_level_kept", rx_level, 16);
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr_data%0d", i), rx_data, 8'(16 + i));
            @(negedge clk);
        end
        rx_ready = 1'b0;
        check("ovr_drained", rx_valid, 0);

        send_rx(8'h55, ^8'h55, 1'b0);
        repeat (2) @(negedge clk);
        check("ferr_flag", rx_frame_err, 1);
        check("ferr_level", rx_level, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ferr_cleared", rx_frame_err, 0);
        rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        rx_pin = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_level", rx_level, 0);
        check("glitch_errs", {rx_overrun, rx_frame_err}, 0);
        send_rx(8'hC3, ^8'hC3, 1'b1);
        repeat (2) @(negedge clk);
        check("rxc3_data", rx_data, 8'hC3);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;

`ifdef UART_PARITY_EN
        send_rx(8'h07, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("par_ok_data", rx_data, 8'h07);
        check("par_ok_flag", rx_parity_err, 0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        send_rx(8'h07, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("par_bad_flag", rx_parity_err, 1);
        check("par_bad_level", rx_level, 0);
`endif

        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (25) @(negedge clk);
        check("midrst_low", tx_pin, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pin_high", tx_pin, 1);
        check("midrst_idle", tx_idle, 1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
